// File: rtl/ysyx_23060187_pkg.sv
// Shared definitions for the NPC instruction fetch slice: FSM and PC-select
// encodings, reset constants and the PC alignment helper.
package ysyx_23060187_pkg;

    localparam int                INST_W           = 32;
    localparam logic [INST_W-1:0] NOP_INST         = 32'h0000_0013;
    localparam logic [31:0]       DEFAULT_RESET_PC = 32'h8000_0000;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_OUT  = 2'd2
    } if_state_e;

    typedef enum logic [1:0] {
        PC_HOLD  = 2'd0,
        PC_INC   = 2'd1,
        PC_REDIR = 2'd2
    } pc_sel_e;

    function automatic logic [31:0] align_pc(input logic [31:0] pc);
        return pc & ~32'd3;
    endfunction

endpackage

// File: rtl/ysyx_23060187_inst_fetch_if.sv
// Fetch-unit bus bundle: redirect input, instruction-memory request/response
// channel and the decode-side instruction channel.
interface ysyx_23060187_inst_fetch_if;
    import ysyx_23060187_pkg::*;

    // Handshakes: a request/instruction transfers on a cycle where valid and
    // ready are both high; valid is never withdrawn and its payload never
    // changes before that transfer, except when a redirect cancels it.
    // The memory response is valid-only (single-cycle rsp_valid pulse).
    logic              redirect_valid;
    logic [31:0]       redirect_pc;

    logic              req_valid;
    logic [31:0]       req_addr;
    logic              req_ready;
    logic              rsp_valid;
    logic [INST_W-1:0] rsp_data;
    logic              rsp_err;

    logic              inst_valid;
    logic [INST_W-1:0] inst;
    logic [31:0]       inst_pc;
    logic              inst_fault;
    logic              inst_ready;

    modport master (
        input  redirect_valid, redirect_pc,
        output req_valid, req_addr,
        input  req_ready, rsp_valid, rsp_data, rsp_err,
        output inst_valid, inst, inst_pc, inst_fault,
        input  inst_ready
    );

    modport slave (
        output redirect_valid, redirect_pc,
        input  req_valid, req_addr,
        output req_ready, rsp_valid, rsp_data, rsp_err,
        input  inst_valid, inst, inst_pc, inst_fault,
        output inst_ready
    );

endinterface

// File: rtl/ysyx_23060187_pc_reg.sv
// Program counter: hold, sequential +4 (wraps modulo 2^32) or aligned
// redirect target; resets asynchronously to RESET_PC.
module ysyx_23060187_pc_reg
    import ysyx_23060187_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst_n,
    input  pc_sel_e     i_sel,
    input  logic [31:0] i_redirect_pc,
    output logic [31:0] o_pc
);

    logic [31:0] r_pc;
    logic [31:0] w_pc_nxt;

    always_comb begin
        w_pc_nxt = r_pc;
        case (i_sel)
            PC_INC:   w_pc_nxt = r_pc + 32'd4;
            PC_REDIR: w_pc_nxt = align_pc(i_redirect_pc);
            default:  w_pc_nxt = r_pc;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_pc <= align_pc(RESET_PC);
        else        r_pc <= w_pc_nxt;
    end

    assign o_pc = r_pc;

endmodule

// File: rtl/ysyx_23060187_inst_fetch.sv
// Instruction fetch unit: one outstanding memory request at a time, a single
// instruction buffer towards decode, and redirects that squash stale work.
module ysyx_23060187_inst_fetch
    import ysyx_23060187_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic                        clk,
    input  logic                        rst_n,
    ysyx_23060187_inst_fetch_if.master  io_bus,
    output if_state_e                   o_dbg_state
);

    if_state_e         r_state;
    if_state_e         w_state_nxt;
    logic              r_drop;
    logic              w_drop_nxt;
    logic [INST_W-1:0] r_inst;
    logic [31:0]       r_inst_pc;
    logic              r_inst_fault;
    logic              w_latch;
    logic              w_req_valid;
    logic              w_inst_valid;
    pc_sel_e           w_pc_sel;
    logic [31:0]       w_pc;

    ysyx_23060187_pc_reg #(.RESET_PC(RESET_PC)) u_pc_reg (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_sel         (w_pc_sel),
        .i_redirect_pc (io_bus.redirect_pc),
        .o_pc          (w_pc)
    );

    always_comb begin
        w_state_nxt  = r_state;
        w_drop_nxt   = r_drop;
        w_pc_sel     = PC_HOLD;
        w_latch      = 1'b0;
        w_req_valid  = 1'b0;
        w_inst_valid = 1'b0;
        case (r_state)
            S_REQ: begin
                w_req_valid = ~io_bus.redirect_valid;
                if (io_bus.redirect_valid)  w_pc_sel    = PC_REDIR;
                else if (io_bus.req_ready)  w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                // A response always frees the memory slot, even when it is stale.
                if (io_bus.rsp_valid) begin
                    w_state_nxt = S_REQ;
                    w_drop_nxt  = 1'b0;
                    if (io_bus.redirect_valid) begin
                        w_pc_sel = PC_REDIR;
                    end else if (!r_drop) begin
                        w_latch     = 1'b1;
                        w_state_nxt = S_OUT;
                    end
                end else if (io_bus.redirect_valid) begin
                    w_pc_sel   = PC_REDIR;
                    w_drop_nxt = 1'b1;
                end
            end
            S_OUT: begin
                w_inst_valid = 1'b1;
                if (io_bus.redirect_valid) begin
                    w_pc_sel    = PC_REDIR;
                    w_state_nxt = S_REQ;
                end else if (io_bus.inst_ready) begin
                    w_pc_sel    = PC_INC;
                    w_state_nxt = S_REQ;
                end
            end
            default: w_state_nxt = S_REQ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_REQ;
            r_drop       <= 1'b0;
            r_inst       <= NOP_INST;
            r_inst_pc    <= align_pc(RESET_PC);
            r_inst_fault <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_drop  <= w_drop_nxt;
            if (w_latch) begin
                r_inst       <= io_bus.rsp_data;
                r_inst_pc    <= w_pc;
                r_inst_fault <= io_bus.rsp_err;
            end
        end
    end

    assign io_bus.req_valid  = w_req_valid;
    assign io_bus.req_addr   = w_pc;
    assign io_bus.inst_valid = w_inst_valid;
    assign io_bus.inst       = r_inst;
    assign io_bus.inst_pc    = r_inst_pc;
    assign io_bus.inst_fault = r_inst_fault;
    assign o_dbg_state       = r_state;

endmodule

// File: doc/ysyx_23060187_inst_fetch.md
# ysyx_23060187_inst_fetch

Instruction fetch unit for the NPC core, directly upstream of the instruction decoder. Owns the PC register, issues one 32-bit fetch at a time to instruction memory over a valid/ready request and valid-only response channel, and presents the fetched word plus its PC to decode over a valid/ready handshake. Accepts redirects (jumps, branches, traps) from execute/writeback at any time and discards stale in-flight responses.

## Interface
- RESET_PC, 32'h8000_0000, PC value loaded on reset
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- redirect_valid  in  1  load redirect_pc as next fetch PC
- redirect_pc  in  32  target PC; bits [1:0] ignored (treated as 0)
- req_valid  out  1  fetch request to instruction memory
- req_addr  out  32  fetch address (= current PC)
- req_ready  in  1  memory accepts request this cycle
- rsp_valid  in  1  response word valid (1-cycle pulse, ≥1 cycle after acceptance)
- rsp_data  in  32  fetched instruction
- rsp_err  in  1  access fault for this response
- inst_valid  out  1  instruction available to decode
- inst  out  32  instruction word
- inst_pc  out  32  PC of inst
- inst_fault  out  1  rsp_err captured with inst
- inst_ready  in  1  decode consumes instruction

## Operation
- FSM states: S_REQ, S_WAIT, S_OUT. Registers: pc, state, drop, inst, inst_pc, inst_fault.
- S_REQ: req_valid = ~redirect_valid; req_addr = pc. Redirect → pc ← redirect_pc & ~3, stay S_REQ. Else req_ready → S_WAIT.
- S_WAIT: req_valid = 0. rsp_valid & drop → drop ← 0, S_REQ (response discarded). rsp_valid & ~drop & ~redirect_valid → latch inst ← rsp_data, inst_pc ← pc, inst_fault ← rsp_err, S_OUT. rsp_valid & redirect_valid → discard, pc ← redirect target, S_REQ. Redirect without rsp_valid → pc ← target, drop ← 1, stay S_WAIT.
- S_OUT: inst_valid = 1, outputs stable until leaving. Redirect wins over inst_ready: pc ← target, S_REQ, instruction dropped. Else inst_ready → pc ← pc + 4, S_REQ.
- PC arithmetic modulo 2^32: 32'hFFFF_FFFC + 4 = 32'h0000_0000. pc[1:0] always 0.
- Exactly one outstanding request; no new request until previous response received (including dropped ones).
- inst_fault forwarded, not acted on; decode/trap logic issues the redirect.

## Timing
- Reset values: pc = RESET_PC, state = S_REQ, drop = 0, inst = 32'h0000_0013 (NOP), inst_pc = RESET_PC, inst_fault = 0; hence req_valid = 1, inst_valid = 0 immediately after reset release.
- Reset mid-operation: all state returns asynchronously to reset values; an in-flight response arriving afterwards is a memory-side protocol violation (memory reset together with core).
- Zero-wait memory: request accepted cycle N, rsp_valid N+1, inst_valid N+2, next req_valid N+3 if inst_ready at N+2. Throughput 1 instruction / 3 cycles.
- req_valid, once asserted without redirect, held with req_addr stable until req_ready.
- Redirect takes effect on the edge where sampled; redirect target appears on req_addr the next cycle.

## Structure
- Shared package ysyx_23060187_pkg: state encoding (S_REQ/S_WAIT/S_OUT), NOP constant 32'h0000_0013, default RESET_PC, INST_W = 32.
- One sub-module: ysyx_23060187_pc_reg — PC register with async reset to RESET_PC, next-PC mux (hold / +4 / redirect), alignment mask.

## Test plan
- Reset release, zero-wait memory returning 32'h0000_0093 at 0x8000_0000 → req_addr 0x8000_0000, inst_valid cycle 2, inst_pc 0x8000_0000; next req_addr 0x8000_0004.
- inst_ready low 5 cycles in S_OUT → inst/inst_pc held, req_valid 0; on inst_ready high, single advance to pc+4.
- Redirect to 0x8000_0102 in S_WAIT, response 2 cycles later → response discarded, inst_valid stays 0, next req_addr 0x8000_0100.
- Redirect coincident with rsp_valid, and redirect coincident with inst_ready in S_OUT → both drop the instruction, next req_addr = redirect target, no +4.
- pc 0xFFFF_FFFC consumed → next req_addr 0x0000_0000; rsp_err = 1 → inst_fault = 1 with that inst only.
- Random req_ready/rsp latency stall plus random redirects, scoreboard against reference PC model → no dropped/duplicated PCs, never two outstanding requests.
